// File: rtl/mod10_cmd_sequencer.sv
// Command sequencer for the mod10 counter: round-robin arbitration between
// two requesters and timed application of the granted ctrl/inp.
module mod10_cmd_sequencer #(
    parameter int                CTRL_W    = 3,
    parameter int                DATA_W    = 4,
    parameter int                TICK_W    = 8,
    parameter logic [CTRL_W-1:0] HOLD_CTRL = '0
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [DATA_W-1:0] req0_inp,
    input  logic [TICK_W-1:0] req0_ticks,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [DATA_W-1:0] req1_inp,
    input  logic [TICK_W-1:0] req1_ticks,
    input  logic              abort,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] inp,
    output logic              busy,
    output logic              grant_id,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_last;
    logic [TICK_W-1:0] r_ticks;
    logic [TICK_W-1:0] r_cnt;

    logic              w_idle;
    logic              w_pick1;
    logic              w_accept;
    logic [CTRL_W-1:0] w_ctrl;
    logic [DATA_W-1:0] w_inp;
    logic [TICK_W-1:0] w_ticks;
    logic [TICK_W-1:0] w_cnt_nx;
    logic              w_last_tick;

    // Arbitration: requester 1 wins if alone, or if both ask and 0 went last
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_pick1     = req1_valid & (~req0_valid | ~r_last);
        req1_ready  = w_idle & w_pick1;
        req0_ready  = w_idle & req0_valid & ~w_pick1;
        w_accept    = req0_ready | req1_ready;
        w_ctrl      = w_pick1 ? req1_ctrl  : req0_ctrl;
        w_inp       = w_pick1 ? req1_inp   : req0_inp;
        w_ticks     = w_pick1 ? req1_ticks : req0_ticks;
        w_cnt_nx    = r_cnt + 1'b1;
        w_last_tick = clk_en & (w_cnt_nx == r_ticks);
    end

    // Sequencer FSM with registered counter-facing outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_ticks  <= '0;
            r_cnt    <= '0;
            ctrl     <= HOLD_CTRL;
            inp      <= '0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    if (w_accept) begin
                        r_state  <= S_RUN;
                        r_last   <= w_pick1;
                        grant_id <= w_pick1;
                        ctrl     <= w_ctrl;
                        inp      <= w_inp;
                        busy     <= 1'b1;
                        r_cnt    <= '0;
                        // A zero duration still applies the command for one tick
                        r_ticks  <= (w_ticks == '0) ? TICK_W'(1) : w_ticks;
                    end
                end
                S_RUN: begin
                    if (abort || w_last_tick) begin
                        r_state <= S_DONE;
                        ctrl    <= HOLD_CTRL;
                        inp     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= abort;
                    end else if (clk_en) begin
                        r_cnt <= w_cnt_nx;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    aborted <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod10_cmd_sequencer.sv
// Scoreboard bench for mod10_cmd_sequencer: driver pushes expected command
// outcomes, a monitor reconstructs each command window and compares.
module tb_mod10_cmd_sequencer;

    localparam logic [2:0] HOLD = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_ctrl, req1_ctrl;
    logic [3:0] req0_inp, req1_inp;
    logic [7:0] req0_ticks, req1_ticks;
    logic       abort;
    logic [2:0] ctrl;
    logic [3:0] inp;
    logic       busy, grant_id, done, aborted;

    mod10_cmd_sequencer #(
        .CTRL_W(3), .DATA_W(4), .TICK_W(8), .HOLD_CTRL(HOLD)
    ) dut (
        .sys_clk(clk), .rst(rst), .clk_en(clk_en),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_ctrl(req0_ctrl), .req0_inp(req0_inp), .req0_ticks(req0_ticks),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_ctrl(req1_ctrl), .req1_inp(req1_inp), .req1_ticks(req1_ticks),
        .abort(abort), .ctrl(ctrl), .inp(inp), .busy(busy),
        .grant_id(grant_id), .done(done), .aborted(aborted)
    );

    typedef struct {
        bit       gid;
        bit [2:0] c;
        bit [3:0] d;
        int       en;
        bit       ab;
        int       run;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   en_mode = 2;
    int   abort_at = 0;
    bit   m_last = 1'b1;

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // clk_en patterns: 0 random, 1 every 4th cycle, 2 tied high
    initial begin
        int ph;
        ph = 0;
        clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0: clk_en = ($urandom_range(0, 2) == 0);
                1: begin
                    ph = (ph + 1) % 4;
                    clk_en = (ph == 0);
                end
                default: clk_en = 1'b1;
            endcase
        end
    end

    // Monitor: rebuild each command window from the outputs
    bit       in_run = 0, chg = 0, last_en = 0, prev_done = 0;
    bit       s_gid;
    bit [2:0] s_ctrl;
    bit [3:0] s_inp;
    int       n_en = 0, n_run = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_run = 0;
            prev_done = 0;
        end else begin
            chk("ready_onehot", 32'(req0_ready & req1_ready), 0);
            if (busy || done)
                chk("ready_blocked", 32'(req0_ready | req1_ready), 0);
            if (busy) begin
                if (!in_run) begin
                    in_run = 1; chg = 0; n_en = 0; n_run = 0;
                    s_gid = grant_id; s_ctrl = ctrl; s_inp = inp;
                end else if (ctrl != s_ctrl || inp != s_inp || grant_id != s_gid) begin
                    chg = 1;
                end
                n_run++;
                if (clk_en) n_en++;
                last_en = clk_en;
            end
            if (done) begin
                chk("done_width", 32'(prev_done), 0);
                if (!in_run || q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("grant_id", 32'(s_gid), 32'(e.gid));
                    chk("grant_id_held", 32'(grant_id), 32'(e.gid));
                    chk("run_ctrl", 32'(s_ctrl), 32'(e.c));
                    chk("run_inp", 32'(s_inp), 32'(e.d));
                    chk("en_ticks", 32'(n_en), 32'(e.en));
                    chk("aborted", 32'(aborted), 32'(e.ab));
                    if (e.run >= 0) chk("run_cycles", 32'(n_run), 32'(e.run));
                    if (!e.ab) chk("last_tick_en", 32'(last_en), 1);
                    chk("run_stable", 32'(chg), 0);
                    chk("done_ctrl", 32'(ctrl), 32'(HOLD));
                    chk("done_inp", 32'(inp), 0);
                    chk("done_busy", 32'(busy), 0);
                end
                in_run = 0;
            end else if (in_run && !busy) begin
                n_chk++;
                n_fail++;
                $display("FAIL busy_dropped: got busy=0 expected done pulse at %0t", $time);
                in_run = 0;
            end
            prev_done = done;
        end
    end

    // Wait for a handshake; expected winner comes from the round-robin rule
    task automatic accept();
        int   win;
        int   t;
        bit   seen;
        exp_t e;
        seen = 0;
        win = (req0_valid && req1_valid) ? (m_last ? 0 : 1) : (req1_valid ? 1 : 0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no ready expected req%0d", win);
            return;
        end
        chk("grant_pick", 32'(req1_ready), 32'(win));
        e.gid = win[0];
        e.c   = win ? req1_ctrl : req0_ctrl;
        e.d   = win ? req1_inp  : req0_inp;
        t     = win ? int'(req1_ticks) : int'(req0_ticks);
        e.en  = (t == 0) ? 1 : t;
        e.ab  = 0;
        e.run = (en_mode == 2) ? e.en : -1;
        if (abort_at > 0) begin
            e.ab  = 1;
            e.en  = abort_at;
            e.run = abort_at;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (win == 1) req1_valid = 0;
        else req0_valid = 0;
        m_last = win[0];
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy && !done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input int c, input int d, input int t);
        req0_ctrl = 3'(c); req0_inp = 4'(d); req0_ticks = 8'(t); req0_valid = 1;
    endtask

    task automatic set1(input int c, input int d, input int t);
        req1_ctrl = 3'(c); req1_inp = 4'(d); req1_ticks = 8'(t); req1_valid = 1;
    endtask

    initial begin
        rst = 1; abort = 0;
        req0_valid = 0; req1_valid = 0;
        req0_ctrl = 0; req0_inp = 0; req0_ticks = 0;
        req1_ctrl = 0; req1_inp = 0; req1_ticks = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 32'(ctrl), 32'(HOLD));
        chk("rst_inp", 32'(inp), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        @(posedge clk);
        #1 rst = 0;

        // single command, clk_en every 4th cycle
        en_mode = 1;
        set0(3'b010, 7, 3);
        accept();
        drain();

        // zero duration from requester 1, clk_en tied high
        en_mode = 2;
        set1(5, 9, 0);
        accept();
        drain();

        // abort in IDLE must be ignored
        abort = 1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_abort_busy", 32'(busy), 0);
            chk("idle_abort_done", 32'(done), 0);
        end
        @(posedge clk);
        #1 abort = 0;

        // abort on the 5th RUN cycle together with clk_en
        abort_at = 5;
        set0(4, 3, 200);
        accept();
        repeat (4) @(posedge clk);
        #1 abort = 1;
        @(posedge clk);
        #1 abort = 0;
        abort_at = 0;
        drain();

        // maximum duration
        set1(6, 15, 255);
        accept();
        drain();

        // reset in the middle of a command
        set0(1, 2, 50);
        accept();
        repeat (3) @(posedge clk);
        #1 rst = 1;
        q.delete();
        @(posedge clk);
        #1 rst = 0;
        m_last = 1;
        @(negedge clk);
        chk("mid_rst_ctrl", 32'(ctrl), 32'(HOLD));
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        @(posedge clk);
        #1;

        // both requesters continuously valid: grants alternate from req0
        set0(1, 1, 1);
        set1(2, 2, 1);
        for (int k = 0; k < 6; k++) begin
            accept();
            if (m_last) set1(2, k + 4, 1);
            else set0(1, k + 4, 1);
        end
        req0_valid = 0;
        req1_valid = 0;
        drain();

        // randomized traffic with random clk_en
        en_mode = 0;
        for (int k = 0; k < 30; k++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1)
                set0(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 5)));
            if (!req1_valid && $urandom_range(0, 1) == 1)
                set1(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 5)));
            if (!req0_valid && !req1_valid)
                set0(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 5)));
            accept();
        end
        req0_valid = 0;
        req1_valid = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mod10_cmd_sequencer.md
Name: mod10_cmd_sequencer

Overview:
- Schedules control commands for the mod10 counter datapath and shares its ctrl/inp inputs between two requesters (e.g. a local switch interface and a remote/host interface).
- Arbitrates between them round-robin and drives the granted command's ctrl/inp onto the counter for a programmed number of clk_en ticks.
- Returns the counter to a hold code afterwards.
- Sits between the requesters and the counter, on sys_clk, consuming the same clk_en tick the counter uses.

Parameters:
- CTRL_W, 3, width of counter control code.
- DATA_W, 4, width of counter load/data input.
- TICK_W, 8, width of per-command tick count.
- HOLD_CTRL, 3'b000, ctrl code driven when no command is active (counter holds value).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  one-cycle tick from the clock divider; same tick the counter advances on.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_ctrl  in  CTRL_W  requester 0 ctrl code.
- req0_inp  in  DATA_W  requester 0 data.
- req0_ticks  in  TICK_W  requester 0 duration in clk_en ticks.
- req1_valid / req1_ready / req1_ctrl / req1_inp / req1_ticks  same as requester 0, for requester 1.
- abort  in  1  terminate the active command early.
- ctrl  out  CTRL_W  to counter ctrl.
- inp  out  DATA_W  to counter inp.
- busy  out  1  a command is being applied.
- grant_id  out  1  requester owning the current or last command.
- done  out  1  one-cycle pulse at command completion.
- aborted  out  1  valid with done; 1 = command ended by abort.

Behaviour:
- Reset (rst=1 at a clock edge), registered outputs:
  - ctrl=HOLD_CTRL, inp=0, busy=0, grant_id=0, done=0, aborted=0.
  - State IDLE; round-robin pointer set so requester 0 wins the first tie.
  - Reset mid-command abandons it immediately with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, for exactly one requester.
    - Both valid: the one not granted last wins.
    - One valid: that one wins.
    - Neither valid: both ready=0.
  - Requesters must not make valid depend on ready. Valid/payload must stay stable until accepted.
  - Handshake (valid & ready) at edge T:
    - Latch ctrl, inp, ticks. Set grant_id and update the RR pointer.
    - Go to RUN. From T+1: ctrl/inp = latched values, busy=1.
  - Latched ticks=0 is treated as 1.
- RUN:
  - Tick counter clears on entry and increments on each clk_en=1 cycle in RUN, including the first RUN cycle.
  - On the cycle where clk_en=1 and count+1 == ticks: next state DONE.
  - The counter therefore sees exactly `ticks` enable pulses with the command applied.
  - abort=1 in RUN (any clk_en value): next state DONE with aborted=1. Abort has priority over normal completion in the same cycle.
  - abort is ignored in IDLE and DONE.
- DONE (exactly 1 cycle):
  - ctrl=HOLD_CTRL, inp=0, busy=0, done=1, aborted per cause, both readys=0.
  - Next state IDLE.
  - Minimum spacing between command application windows is 2 cycles (DONE + IDLE handshake cycle).
- Ticks are counted in TICK_W bits with no wrap: max ticks = 2^TICK_W-1.
- clk_en arriving in the handshake cycle is not counted. The counter sees HOLD_CTRL on that tick.
- A requester deasserting valid in RUN has no effect on the running command.
- Outputs ctrl, inp, busy, done, aborted, grant_id are registered. Only the readys are combinational.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, all valids=0.
  - Required: ctrl=HOLD_CTRL, inp=0, busy=0, done=0, readys=0.
- Single command:
  - Stimulus: req0 ctrl=3'b010, inp=4'd7, ticks=3; clk_en every 4th cycle.
  - Required: req0_ready for 1 cycle; ctrl=010/inp=7 from next cycle until the 3rd clk_en in RUN; then 1 cycle DONE with done=1, aborted=0, grant_id=0, ctrl=HOLD_CTRL.
- Round robin:
  - Stimulus: req0 and req1 both valid continuously, ticks=1.
  - Required: grants alternate 0,1,0,1; first grant to req0; never the same requester twice while the other is valid.
- ticks=0:
  - Stimulus: req1 ticks=0, clk_en tied 1.
  - Required: exactly 1 RUN cycle, done on the following cycle, grant_id=1.
- Abort:
  - Stimulus: req0 ticks=200; abort=1 on the 5th RUN cycle, coincident with clk_en.
  - Required: next cycle done=1, aborted=1, ctrl=HOLD_CTRL; abort asserted in IDLE has no effect.
- Reset mid-RUN:
  - Stimulus: rst=1 during RUN with ticks=50.
  - Required: next cycle ctrl=HOLD_CTRL, busy=0, no done pulse; a following simultaneous request grants req0.
